// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin ultrasonic ranger sequencer.
// Fires one sensor at a time, times its echo and logs per-sensor results.
module sonar_scheduler #(
    parameter int  N_SENSORS      = 4,
    parameter int  TRIG_CYCLES    = 600,
    parameter int  TIMEOUT_CYCLES = 3500000,
    parameter int  GUARD_CYCLES   = 1500000,
    parameter int  CNT_W          = 32,
    localparam int ID_W           = $clog2(N_SENSORS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] sensor_mask,
    output logic [N_SENSORS-1:0] trigger,
    input  logic [N_SENSORS-1:0] echo,
    output logic                 sample_valid,
    output logic [ID_W-1:0]      sample_id,
    output logic [CNT_W-1:0]     sample_distance,
    output logic                 sample_timeout,
    input  logic [ID_W-1:0]      rd_sel,
    output logic [CNT_W-1:0]     rd_distance,
    output logic                 rd_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    state_t               state;
    logic [ID_W-1:0]      cur;
    logic [ID_W-1:0]      last;
    logic [ID_W-1:0]      nxt;
    logic [ID_W-1:0]      jj;
    logic                 found;
    logic [CNT_W-1:0]     phase;
    logic [CNT_W-1:0]     width;
    logic [N_SENSORS-1:0] echo_m;
    logic [N_SENSORS-1:0] echo_s;
    logic [CNT_W-1:0]     rf_dist [N_SENSORS];
    logic [N_SENSORS-1:0] rf_to;
    logic                 ech;
    logic                 ph_end;
    logic                 fin;
    logic                 fin_to;
    logic [CNT_W-1:0]     fin_dist;

    assign ech         = echo_s[cur];
    assign ph_end      = (phase == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fin_dist    = fin_to ? '1 : width;
    assign rd_distance = rf_dist[rd_sel];
    assign rd_timeout  = rf_to[rd_sel];

    // first enabled sensor after the last one served, wrapping
    always_comb begin
        nxt   = last;
        jj    = '0;
        found = 1'b0;
        for (int k = 1; k <= N_SENSORS; k++) begin
            jj = ID_W'((int'(last) + k) % N_SENSORS);
            if (!found && sensor_mask[jj]) begin
                nxt   = jj;
                found = 1'b1;
            end
        end
    end

    // timeout outranks an echo decision landing on the same cycle
    always_comb begin
        fin    = 1'b0;
        fin_to = 1'b0;
        if (state == WAIT_RISE || state == MEASURE) begin
            if (ph_end) begin
                fin    = 1'b1;
                fin_to = 1'b1;
            end else if (state == MEASURE && !ech) begin
                fin = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cur             <= '0;
            last            <= ID_W'(N_SENSORS - 1);
            phase           <= '0;
            width           <= '0;
            echo_m          <= '0;
            echo_s          <= '0;
            trigger         <= '0;
            sample_valid    <= 1'b0;
            sample_id       <= '0;
            sample_distance <= '0;
            sample_timeout  <= 1'b0;
            rf_to           <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                rf_dist[i] <= '0;
            end
        end else begin
            echo_m       <= echo;
            echo_s       <= echo_m;
            sample_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable && |sensor_mask) begin
                        cur     <= nxt;
                        trigger <= N_SENSORS'(1) << nxt;
                        phase   <= '0;
                        state   <= TRIG;
                    end
                end
                TRIG: begin
                    if (phase == CNT_W'(TRIG_CYCLES - 1)) begin
                        trigger <= '0;
                        phase   <= '0;
                        state   <= WAIT_RISE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    phase <= phase + 1'b1;
                    if (!ph_end && ech) begin
                        width <= CNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    phase <= phase + 1'b1;
                    if (ech && width != '1) begin
                        width <= width + 1'b1;
                    end
                end
                GUARD: begin
                    if (phase == CNT_W'(GUARD_CYCLES - 1)) begin
                        phase <= '0;
                        state <= IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (fin) begin
                rf_dist[cur]    <= fin_dist;
                rf_to[cur]      <= fin_to;
                sample_valid    <= 1'b1;
                sample_id       <= cur;
                sample_distance <= fin_dist;
                sample_timeout  <= fin_to;
                last            <= cur;
                phase           <= '0;
                state           <= GUARD;
            end
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: randomized slot-level bench for sonar_scheduler.
// A per-slot echo model predicts sensor order, latency and results.
module tb_sonar_scheduler;

    localparam int N    = 4;
    localparam int TRIG = 4;
    localparam int TMO  = 100;
    localparam int GRD  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  sensor_mask;
    logic [3:0]  trigger;
    logic [3:0]  echo;
    logic        sample_valid;
    logic [1:0]  sample_id;
    logic [31:0] sample_distance;
    logic        sample_timeout;
    logic [1:0]  rd_sel;
    logic [31:0] rd_distance;
    logic        rd_timeout;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          last_m;
    logic [3:0]  mask_m;
    logic [31:0] rf_d [N];
    logic        rf_t [N];
    bit          chained;

    always #5 clk = ~clk;

    sonar_scheduler #(
        .N_SENSORS(N),
        .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO),
        .GUARD_CYCLES(GRD),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sensor_mask(sensor_mask),
        .trigger(trigger),
        .echo(echo),
        .sample_valid(sample_valid),
        .sample_id(sample_id),
        .sample_distance(sample_distance),
        .sample_timeout(sample_timeout),
        .rd_sel(rd_sel),
        .rd_distance(rd_distance),
        .rd_timeout(rd_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int next_id(input int l, input logic [3:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[2'((l + k) % N)]) return (l + k) % N;
        end
        return -1;
    endfunction

    task automatic set_mask(input logic [3:0] m);
        sensor_mask = m;
        mask_m      = m;
    endtask

    task automatic model_reset();
        last_m  = N - 1;
        chained = 1'b0;
        for (int i = 0; i < N; i++) begin
            rf_d[i] = '0;
            rf_t[i] = 1'b0;
        end
    endtask

    // a: first raw-echo sample index after trigger fall, w: high cycles
    task automatic run_slot(input int a, input int w, input int chg_at,
                            input logic [3:0] chg_mask, input bit dis_trig,
                            input bit hold, input int rst_at);
        int          id;
        int          k;
        int          tw;
        int          done;
        int          exp_done;
        bit          exp_to;
        bit          quiet;
        logic [3:0]  sel;
        logic [31:0] exp_d;
        id       = next_id(last_m, mask_m);
        sel      = 4'b1 << id;
        exp_to   = (w == 0) || (a + w + 2 >= TMO);
        exp_done = exp_to ? TMO : a + w + 2;
        exp_d    = exp_to ? 32'hFFFF_FFFF : 32'(w);
        k = 0;
        while (trigger == 4'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("trig_start", trigger != 4'b0, 1);
        if (trigger == 4'b0) return;
        if (chained) chk("guard_gap", k, GRD);
        chk("trig_id", trigger, sel);
        if (dis_trig) enable = 1'b0;
        tw    = 0;
        quiet = 1'b1;
        while (trigger != 4'b0 && tw < 50) begin
            if (trigger != sel) quiet = 1'b0;
            tw++;
            @(negedge clk);
        end
        chk("trig_onehot", quiet, 1);
        chk("trig_width", tw, TRIG);
        done = -1;
        for (k = 0; k < 300; k++) begin
            if (sample_valid) begin
                done = k;
                break;
            end
            if (trigger != 4'b0) quiet = 1'b0;
            if (k == rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst_trig", trigger, 0);
                chk("rst_valid", sample_valid, 0);
                quiet = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (sample_valid) quiet = 1'b0;
                end
                chk("rst_no_sample", quiet, 1);
                echo = '0;
                model_reset();
                return;
            end
            echo = (4'($urandom) & ~sel) |
                   ((a <= k + 1 && k + 1 <= a + w - 1) ? sel : 4'b0);
            if (k == chg_at) set_mask(chg_mask);
            @(negedge clk);
        end
        chk("trig_quiet", quiet, 1);
        chk("sample_seen", done >= 0, 1);
        if (done < 0) begin
            echo    = '0;
            chained = 1'b0;
            return;
        end
        chk("done_lat", done, exp_done);
        chk("s_id", sample_id, id);
        chk("s_dist", sample_distance, exp_d);
        chk("s_to", sample_timeout, exp_to);
        rf_d[id] = exp_d;
        rf_t[id] = exp_to;
        last_m   = id;
        rd_sel   = 2'(id);
        #1;
        chk("rd_dist", rd_distance, rf_d[id]);
        chk("rd_to", rd_timeout, rf_t[id]);
        if (!hold) echo = '0;
        @(negedge clk);
        chk("s_pulse", sample_valid, 0);
        chk("s_hold", sample_distance, exp_d);
        chained = enable && (mask_m != 4'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a;
        int  w;
        bit  quiet;
        int  k;
        reset  = 1'b0;
        enable = 1'b0;
        echo   = '0;
        rd_sel = '0;
        set_mask(4'b0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_trigger", trigger, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_id", sample_id, 0);
        chk("rst_dist", sample_distance, 0);
        chk("rst_to", sample_timeout, 0);
        for (int i = 0; i < N; i++) begin
            rd_sel = 2'(i);
            #1;
            chk("rst_rd_dist", rd_distance, 0);
            chk("rst_rd_to", rd_timeout, 0);
        end
        reset = 1'b1;
        @(negedge clk);

        set_mask(4'b1111);
        enable = 1'b1;
        repeat (5) run_slot(5, 20, -1, 4'b0, 0, 0, -1);

        repeat (10) begin
            a = int'($urandom_range(1, 40));
            w = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 70));
            run_slot(a, w, -1, 4'b0, 0, 0, -1);
        end

        set_mask(4'b0010);
        run_slot(5, 0, -1, 4'b0, 0, 0, -1);
        rd_sel = 2'd1;
        #1;
        chk("tmo_rd_dist", rd_distance, 32'hFFFF_FFFF);
        chk("tmo_rd_to", rd_timeout, 1);

        set_mask(4'b0100);
        run_slot(10, 1000, -1, 4'b0, 0, 1, -1);
        run_slot(-5, 1000, -1, 4'b0, 0, 0, -1);

        set_mask(4'b1010);
        repeat (2) begin
            if (next_id(last_m, mask_m) != 3)
                run_slot(6, 10, -1, 4'b0, 0, 0, -1);
        end
        run_slot(5, 30, 12, 4'b0010, 0, 0, -1);
        repeat (2) run_slot(8, 15, -1, 4'b0, 0, 0, -1);

        run_slot(6, 12, -1, 4'b0, 1, 0, -1);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (trigger != 4'b0 || sample_valid) quiet = 1'b0;
        end
        chk("idle_hold", quiet, 1);

        set_mask(4'b1111);
        enable  = 1'b1;
        chained = 1'b0;
        run_slot(5, 40, -1, 4'b0, 0, 0, 20);
        for (int i = 0; i < N; i++) begin
            rd_sel = 2'(i);
            #1;
            chk("arst_rd_dist", rd_distance, 0);
            chk("arst_rd_to", rd_timeout, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        run_slot(5, 20, -1, 4'b0, 0, 0, -1);

        k = 0;
        while (trigger == 4'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("trig2_start", trigger != 4'b0, 1);
        reset = 1'b0;
        #1;
        chk("trig_async_drop", trigger, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sonar_scheduler.md
Name: sonar_scheduler

Overview:
- Time-multiplexes up to N ultrasonic rangers so only one fires at a time, avoiding acoustic crosstalk.
- For each enabled sensor in round-robin order, the block:
  - generates that sensor's trigger pulse;
  - measures its echo pulse width in clk cycles;
  - handles no-echo timeout;
  - enforces a quiet guard interval before the next sensor fires.
- Results go into a per-sensor register file and are also announced as a one-cycle sample strobe to the motion/control logic.

Parameters:
- N_SENSORS, 4, number of sonar channels (2..16).
- TRIG_CYCLES, 600, trigger pulse width in clk cycles.
- TIMEOUT_CYCLES, 3500000, maximum cycles from trigger falling edge to echo end before the slot is declared timed out.
- GUARD_CYCLES, 1500000, quiet cycles after each slot before the next trigger.
- CNT_W, 32, width of the distance and phase counters.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- enable, input, 1, scheduler run enable.
- sensor_mask, input, N_SENSORS, bit i=1 includes sensor i in the rotation.
- trigger, output, N_SENSORS, per-sensor trigger; registered; at most one bit high.
- echo, input, N_SENSORS, raw per-sensor echo (asynchronous).
- sample_valid, output, 1, one-cycle strobe when a slot completes.
- sample_id, output, $clog2(N_SENSORS), sensor index of the completed slot.
- sample_distance, output, CNT_W, echo width in cycles, or all-ones on timeout.
- sample_timeout, output, 1, completed slot timed out.
- rd_sel, input, $clog2(N_SENSORS), register-file read select.
- rd_distance, output, CNT_W, last distance of sensor rd_sel (combinational read).
- rd_timeout, output, 1, last-slot timeout flag of sensor rd_sel.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; trigger=0; sample_valid=0; sample_id=0; sample_distance=0; sample_timeout=0.
  - All register-file distances=0 and timeouts=0; last=N_SENSORS-1; echo synchronizers=0.
- Reset asserted mid-slot aborts immediately: trigger drops asynchronously and no sample is emitted.
- Each echo bit passes through a 2-FF synchronizer (echo_s). All echo decisions use echo_s only.
- State IDLE:
  - If enable=1 and sensor_mask!=0: cur = first set mask bit searching (last+1) mod N upward with wrap; go to TRIG next cycle.
  - Otherwise stay in IDLE.
- State TRIG:
  - trigger[cur]=1 for exactly TRIG_CYCLES consecutive cycles, then low.
  - Go to WAIT_RISE with phase counter=0.
- State WAIT_RISE:
  - Phase counter increments each cycle.
  - echo_s[cur]=1: go to MEASURE with width=1.
  - Phase reaching TIMEOUT_CYCLES first: go to timeout completion.
- State MEASURE:
  - width increments each cycle echo_s[cur]=1, saturating at 2^CNT_W-1. Phase counter keeps incrementing.
  - echo_s[cur]=0: normal completion with distance=width.
  - Phase reaching TIMEOUT_CYCLES first: timeout completion.
  - Recorded width equals raw echo high time in cycles; latency is 2 cycles due to synchronizer.
- Completion (single cycle, on the transition to GUARD):
  - Write regfile[cur] = {distance, timeout}. On timeout, distance=all-ones and timeout=1.
  - Assert sample_valid for one cycle with sample_id=cur, sample_distance, sample_timeout.
  - Set last=cur.
- State GUARD:
  - All trigger bits low; echoes ignored.
  - Wait GUARD_CYCLES, then return to IDLE. The IDLE decision is made on the following cycle.
- Echo already high at WAIT_RISE entry counts as the rising echo (width starts at 1).
- Echoes on non-selected sensors are ignored at all times.
- Changes to enable or sensor_mask take effect only in IDLE; an in-progress slot always completes through GUARD.
- Clearing mask bit cur mid-slot still produces that slot's sample.
- Single-bit mask: the same sensor repeats each period.
- Register-file write and a same-cycle rd_sel read of the same entry return the old value; the new value appears the next cycle.
- sample_* hold their last values when sample_valid=0.

Test Plan:
- Bench parameters for all scenarios: N=4, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, GUARD_CYCLES=10.
- Round-robin: mask=4'b1111, enable=1, each echo high 20 cycles starting 5 cycles after its trigger falls -> trigger pulses 4 cycles wide, one-hot, order 0,1,2,3,0. Each sample_valid has distance=20, timeout=0; ≥10 quiet cycles between slots.
- Timeout: mask=4'b0010, echo[1] never rises -> sample_id=1, distance=32'hFFFFFFFF, timeout=1, issued 100 cycles after trigger falls. rd_sel=1 then reads the same values.
- Stuck echo: echo[2] rises 10 cycles after trigger and stays high, mask=4'b0100 -> timeout at phase 100, distance all-ones, timeout=1. The following slot still re-triggers sensor 2.
- Skip and mask change: mask=4'b1010, clear bit 3 during sensor 3's MEASURE -> sensor 3 sample still emitted; subsequent slots use sensor 1 only.
- Enable/reset: deassert enable during TRIG -> slot completes and the block then stays IDLE with trigger=0. Assert reset mid-MEASURE -> trigger=0 immediately, no sample, all rd_distance=0, and first slot after release is sensor 0.
